// File: rtl/seu_pulse_injector.sv
// Emits bursts of active-low SEU-like pulses on a registered output for counter self-test.
// Latency: first low cycle is the cycle after start accept; done is 1 cycle after the final gap.
// Backpressure: none; start is ignored while busy and abort only shortens the running burst.
module seu_pulse_injector #(
    parameter int CNT_W   = 32,
    parameter int WIDTH_W = 8,
    parameter int GAP_W   = 16,
    parameter int MIN_GAP = 12
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    input  logic [CNT_W-1:0]   burst_len,
    input  logic [WIDTH_W-1:0] pulse_width,
    input  logic [GAP_W-1:0]   gap,
    output logic               seu_n,
    output logic               busy,
    output logic               done,
    output logic [CNT_W-1:0]   sent_count
);

    typedef enum logic [1:0] {S_IDLE, S_LOW, S_GAP, S_FIN} state_t;

    localparam logic [GAP_W-1:0] MIN_GAP_V = GAP_W'(MIN_GAP);

    state_t             state_q;
    logic               seu_n_q;
    logic               busy_q;
    logic               done_q;
    logic               abort_q;
    logic [CNT_W-1:0]   sent_q;
    logic [CNT_W-1:0]   n_q;
    logic [WIDTH_W-1:0] w_q;
    logic [GAP_W-1:0]   g_q;
    logic [WIDTH_W-1:0] low_cnt_q;
    logic [GAP_W-1:0]   gap_cnt_q;

    logic [WIDTH_W-1:0] w_d;
    logic [GAP_W-1:0]   g_d;
    logic [CNT_W-1:0]   sent_inc_d;
    logic               more_d;

    always_comb begin
        w_d        = (pulse_width == '0) ? WIDTH_W'(1) : pulse_width;
        g_d        = (gap < MIN_GAP_V) ? MIN_GAP_V : gap;
        sent_inc_d = (&sent_q) ? sent_q : sent_q + CNT_W'(1);
        more_d     = (sent_q < n_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            seu_n_q   <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            abort_q   <= 1'b0;
            sent_q    <= '0;
            n_q       <= '0;
            w_q       <= '0;
            g_q       <= '0;
            low_cnt_q <= '0;
            gap_cnt_q <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        n_q     <= burst_len;
                        w_q     <= w_d;
                        g_q     <= g_d;
                        abort_q <= 1'b0;
                        busy_q  <= 1'b1;
                        if (burst_len == '0) begin
                            sent_q  <= '0;
                            state_q <= S_FIN;
                        end else begin
                            // entering LOW from a cleared count: first pulse counts as 1
                            sent_q    <= CNT_W'(1);
                            seu_n_q   <= 1'b0;
                            low_cnt_q <= w_d;
                            state_q   <= S_LOW;
                        end
                    end
                end
                S_LOW: begin
                    if (abort || low_cnt_q == WIDTH_W'(1)) begin
                        seu_n_q   <= 1'b1;
                        gap_cnt_q <= g_q;
                        abort_q   <= abort_q | abort;
                        state_q   <= S_GAP;
                    end else begin
                        low_cnt_q <= low_cnt_q - WIDTH_W'(1);
                    end
                end
                S_GAP: begin
                    abort_q <= abort_q | abort;
                    if (gap_cnt_q == GAP_W'(1)) begin
                        if (abort_q || abort || !more_d) begin
                            state_q <= S_FIN;
                        end else begin
                            seu_n_q   <= 1'b0;
                            low_cnt_q <= w_q;
                            sent_q    <= sent_inc_d;
                            state_q   <= S_LOW;
                        end
                    end else begin
                        gap_cnt_q <= gap_cnt_q - GAP_W'(1);
                    end
                end
                S_FIN: begin
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign seu_n      = seu_n_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign sent_count = sent_q;

endmodule

// File: tb/tb_seu_pulse_injector.sv
// Bench for seu_pulse_injector: table of bursts with a pulse scoreboard, plus reset sequences.
module tb_seu_pulse_injector;

    localparam int CNT_W   = 32;
    localparam int WIDTH_W = 8;
    localparam int GAP_W   = 16;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic               abort;
    logic [CNT_W-1:0]   burst_len;
    logic [WIDTH_W-1:0] pulse_width;
    logic [GAP_W-1:0]   gap;
    logic               seu_n;
    logic               busy;
    logic               done;
    logic [CNT_W-1:0]   sent_count;

    seu_pulse_injector #(
        .CNT_W(CNT_W), .WIDTH_W(WIDTH_W), .GAP_W(GAP_W), .MIN_GAP(12)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .burst_len(burst_len), .pulse_width(pulse_width), .gap(gap),
        .seu_n(seu_n), .busy(busy), .done(done), .sent_count(sent_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int n; int w; int g; int abort_off;
        int done_off; int sent; int pulses; int ew; int eg; int last_w;
    } vec_t;

    typedef struct { int off; int width; } pulse_t;

    vec_t   vecs[7];
    pulse_t exp_q[$];
    int     ncmp = 0;
    int     nfail = 0;
    int     cyc = 0;

    task automatic tick;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check(input string name, input longint act, input longint exp);
        ncmp++;
        if (act != exp) begin
            nfail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic run_case(input vec_t v, input int idx);
        int acc, lstart, falls, done_cyc, ndone;
        logic prev;
        pulse_t e;
        burst_len   = CNT_W'(v.n);
        pulse_width = WIDTH_W'(v.w);
        gap         = GAP_W'(v.g);
        start       = 1'b1;
        abort       = (v.abort_off == 0);
        for (int k = 0; k < v.pulses; k++) begin
            e.off   = k * (v.ew + v.eg);
            e.width = (k == v.pulses - 1) ? v.last_w : v.ew;
            exp_q.push_back(e);
        end
        tick;
        acc         = cyc;
        start       = 1'b0;
        abort       = 1'b0;
        burst_len   = $urandom;
        pulse_width = WIDTH_W'($urandom);
        gap         = GAP_W'($urandom);
        prev        = 1'b1;
        falls       = 0;
        lstart      = 0;
        done_cyc    = -1;
        ndone       = 0;
        check($sformatf("v%0d_busy_after_accept", idx), busy, 1);
        for (int t = 0; t <= v.done_off + 20; t++) begin
            if (prev && !seu_n) begin
                falls++;
                lstart = cyc;
            end
            if (!prev && seu_n) begin
                if (exp_q.size() == 0) begin
                    check($sformatf("v%0d_extra_pulse_width", idx), cyc - lstart, 0);
                end else begin
                    e = exp_q.pop_front();
                    check($sformatf("v%0d_pulse_off", idx), lstart - acc, e.off);
                    check($sformatf("v%0d_pulse_width", idx), cyc - lstart, e.width);
                end
            end
            prev = seu_n;
            if (done) begin
                ndone++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            abort = (v.abort_off > 0) && (cyc - acc == v.abort_off - 1);
            start = (v.done_off > 5) && (cyc - acc == 2);
            tick;
        end
        start = 1'b0;
        abort = 1'b0;
        check($sformatf("v%0d_done_off", idx), done_cyc - acc, v.done_off);
        check($sformatf("v%0d_done_strobes", idx), ndone, 1);
        check($sformatf("v%0d_sent_count", idx), sent_count, v.sent);
        check($sformatf("v%0d_busy_end", idx), busy, 0);
        check($sformatf("v%0d_seu_n_end", idx), seu_n, 1);
        check($sformatf("v%0d_falls", idx), falls, v.pulses);
        check($sformatf("v%0d_missing_pulses", idx), exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        int acc;
        //           n   w   g  ab  done sent pl  ew  eg  lw
        vecs[0] = '{ 3,  4, 20, -1,  73,  3,  3,  4, 20,  4};
        vecs[1] = '{ 2,  0,  2, -1,  27,  2,  2,  1, 12,  1};
        vecs[2] = '{ 0,  7, 30, -1,   1,  0,  0,  1,  1,  1};
        vecs[3] = '{10,  5, 15, 62,  78,  4,  4,  5, 15,  2};
        vecs[4] = '{ 3,  2, 12,  5,  15,  1,  1,  2, 12,  2};
        vecs[5] = '{ 1,255,  5, -1, 268,  1,  1,255, 12,255};
        vecs[6] = '{ 2,  1, 12,  0,  27,  2,  2,  1, 12,  1};

        rst = 1'b1; start = 1'b0; abort = 1'b0;
        burst_len = '0; pulse_width = '0; gap = '0;
        repeat (3) tick;
        check("rst_seu_n", seu_n, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_sent_count", sent_count, 0);
        rst = 1'b0;
        tick;

        abort = 1'b1;
        tick;
        abort = 1'b0;
        tick;
        check("idle_abort_busy", busy, 0);
        check("idle_abort_seu_n", seu_n, 1);

        for (int i = 0; i < 7; i++) begin
            run_case(vecs[i], i);
            tick;
        end

        burst_len = 5; pulse_width = 6; gap = 12; start = 1'b1;
        tick;
        acc   = cyc;
        start = 1'b0;
        while (cyc < acc + 19) tick;
        check("midrst_pre_seu_n", seu_n, 0);
        check("midrst_pre_sent", sent_count, 2);
        rst = 1'b1;
        tick;
        check("midrst_seu_n", seu_n, 1);
        check("midrst_busy", busy, 0);
        check("midrst_sent", sent_count, 0);
        check("midrst_done", done, 0);
        rst = 1'b0;
        tick;
        run_case(vecs[0], 10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
